// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage feeding IF/ID; single-outstanding memory
//            requests with stall hold, redirect and bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DROP = 2'd3;

    logic [1:0]  r_state_q,      w_state_d;
    logic [31:0] r_pc_q,         w_pc_d;
    logic [31:0] r_drop_addr_q,  w_drop_addr_d;
    logic [31:0] r_out_pc_q,     w_out_pc_d;
    logic [31:0] r_out_inst_q,   w_out_inst_d;
    logic        r_out_valid_q,  w_out_valid_d;
    logic [31:0] r_skid_pc_q,    w_skid_pc_d;
    logic [31:0] r_skid_inst_q,  w_skid_inst_d;
    logic        r_skid_valid_q, w_skid_valid_d;

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_drop_addr_d  = r_drop_addr_q;
        w_out_pc_d     = r_out_pc_q;
        w_out_inst_d   = r_out_inst_q;
        w_out_valid_d  = r_out_valid_q;
        w_skid_pc_d    = r_skid_pc_q;
        w_skid_inst_d  = r_skid_inst_q;
        w_skid_valid_d = r_skid_valid_q;

        case (r_state_q)
            c_IDLE: w_state_d = c_REQ;
            c_REQ: begin
                if (i_imem_ack && !i_stall) begin
                    w_out_pc_d    = r_pc_q;
                    w_out_inst_d  = i_imem_rdata;
                    w_out_valid_d = 1'b1;
                    w_pc_d        = r_pc_q + 32'd4;
                end else if (!i_imem_ack && !i_stall) begin
                    w_out_valid_d = 1'b0;
                    w_out_inst_d  = NOP_INST;
                end else if (i_imem_ack && i_stall) begin
                    // Downstream is frozen: park the returned word until release.
                    w_skid_pc_d    = r_pc_q;
                    w_skid_inst_d  = i_imem_rdata;
                    w_skid_valid_d = 1'b1;
                    w_pc_d         = r_pc_q + 32'd4;
                    w_state_d      = c_HOLD;
                end
            end
            c_HOLD: begin
                if (!i_stall) begin
                    w_out_pc_d     = r_skid_pc_q;
                    w_out_inst_d   = r_skid_inst_q;
                    w_out_valid_d  = r_skid_valid_q;
                    w_skid_valid_d = 1'b0;
                    w_state_d      = c_REQ;
                end
            end
            c_DROP: begin
                if (i_imem_ack) begin
                    w_state_d = c_REQ;
                end
            end
            default: w_state_d = c_IDLE;
        endcase

        // Redirect outranks stall; an unacked request must still complete at its old address.
        if (i_redirect) begin
            w_pc_d         = {i_redirect_pc[31:2], 2'b00};
            w_out_valid_d  = 1'b0;
            w_out_inst_d   = NOP_INST;
            w_skid_valid_d = 1'b0;
            if (r_state_q == c_REQ) begin
                w_drop_addr_d = r_pc_q;
            end
            if (((r_state_q == c_REQ) || (r_state_q == c_DROP)) && !i_imem_ack) begin
                w_state_d = c_DROP;
            end else begin
                w_state_d = c_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= c_IDLE;
            r_pc_q         <= RESET_PC;
            r_drop_addr_q  <= 32'd0;
            r_out_pc_q     <= 32'd0;
            r_out_inst_q   <= NOP_INST;
            r_out_valid_q  <= 1'b0;
            r_skid_pc_q    <= 32'd0;
            r_skid_inst_q  <= NOP_INST;
            r_skid_valid_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_drop_addr_q  <= w_drop_addr_d;
            r_out_pc_q     <= w_out_pc_d;
            r_out_inst_q   <= w_out_inst_d;
            r_out_valid_q  <= w_out_valid_d;
            r_skid_pc_q    <= w_skid_pc_d;
            r_skid_inst_q  <= w_skid_inst_d;
            r_skid_valid_q <= w_skid_valid_d;
        end
    end

    assign o_imem_req  = (r_state_q == c_REQ) || (r_state_q == c_DROP);
    assign o_imem_addr = (r_state_q == c_DROP) ? r_drop_addr_q : r_pc_q;
    assign o_pc        = r_out_pc_q;
    assign o_inst      = r_out_inst_q;
    assign o_valid     = r_out_valid_q;

endmodule
`default_nettype wire
